// File: rtl/ycbcr_frame_ctrl.sv
// ycbcr_frame_ctrl
// Frame-level controller for the rgb2ycbcr converter and its bypass mux.
// It measures the active resolution from de_in/vsync_in and takes mode
// requests over a valid/ready handshake. A mode change takes effect only
// on a vsync rising edge, so no output frame mixes two modes. The mux
// select is delayed to match the converter pipeline latency.
//
// Parameters:
//   CNT_W    - width of pixel/line counters and measured resolution
//   CONV_LAT - converter latency in clk cycles (>=1), delay on mode_sel_out
//   FCNT_W   - width of the frame counter
//
// Ports:
//   clk, rst_n           - pixel clock, asynchronous active-low reset
//   de_in/hsync_in/vsync_in - video timing inputs (active-high)
//   cfg_mode/cfg_valid/cfg_ready - mode request handshake
//                          (00 bypass, 01 convert, 10 blank, 11 -> 00)
//   mode_active          - mode in force for the current frame
//   conv_en              - converter enable (de_in registered, convert mode)
//   mode_sel_out         - mode_active delayed CONV_LAT cycles
//   frame_width/height   - resolution of the last completed frame
//   res_valid            - a resolution has been measured
//   res_change           - pulse: committed resolution differs from previous
//   timing_err           - pulse: line length differs from first line,
//                          or a line was cut short by vsync
//   frame_cnt            - frames started since reset (wraps)
//
// Optional feature (define FRAME_CTRL_IRQ_EN):
//   irq     - level interrupt, set by res_change or timing_err
//   irq_clr - clears irq; a set event in the same cycle wins
module ycbcr_frame_ctrl #(
   parameter int CNT_W    = 12,
   parameter int CONV_LAT = 4,
   parameter int FCNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              de_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic [1:0]        cfg_mode,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic [1:0]        mode_active,
   output logic              conv_en,
   output logic [1:0]        mode_sel_out,
   output logic [CNT_W-1:0]  frame_width,
   output logic [CNT_W-1:0]  frame_height,
   output logic              res_valid,
   output logic              res_change,
   output logic              timing_err,
`ifdef FRAME_CTRL_IRQ_EN
   output logic              irq,
   input  logic              irq_clr,
`endif
   output logic [FCNT_W-1:0] frame_cnt
);

   typedef enum logic [1:0] {
      S_WAIT_VS,
      S_WAIT_DE,
      S_ACTIVE,
      S_HBLANK
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_vsync_q;
   logic                r_de_q;
   logic [CNT_W-1:0]    r_pix_cnt;
   logic [CNT_W-1:0]    r_line_cnt;
   logic [CNT_W-1:0]    r_ref_w;
   logic [CNT_W-1:0]    r_frame_width;
   logic [CNT_W-1:0]    r_frame_height;
   logic                r_res_valid;
   logic                r_res_change;
   logic                r_timing_err;
   logic [FCNT_W-1:0]   r_frame_cnt;
   logic                r_cfg_ready;
   logic [1:0]          r_pend_mode;
   logic [1:0]          r_mode_active;
   logic                r_conv_en;
   logic [2*CONV_LAT-1:0] r_mode_sr;

   logic                w_vs_rise;
   logic                w_de_rise;
   logic                w_de_fall;
   logic                w_line_end;
   logic                w_drop_line;
   logic                w_count_pix;
   logic                w_commit;
   logic                w_accept;
   logic                w_timing_err_next;
   logic                w_res_change_next;
   logic [CNT_W-1:0]    w_pix_inc;
   logic [CNT_W-1:0]    w_line_inc;

   // Line boundaries come from de_in alone; hsync is accepted but not needed.
   logic                w_unused_hsync;
   assign w_unused_hsync = hsync_in;

   assign w_vs_rise = vsync_in & ~r_vsync_q;
   assign w_de_rise = de_in & ~r_de_q;
   assign w_de_fall = ~de_in & r_de_q;
   assign w_accept  = cfg_valid & r_cfg_ready;

   // Next-state logic. vsync rising edge overrides every line event.
   always_comb begin
      w_state_next = r_state;
      w_line_end   = 1'b0;
      w_drop_line  = 1'b0;
      if (w_vs_rise) begin
         w_state_next = S_WAIT_DE;
         w_drop_line  = (r_state == S_ACTIVE);
      end else begin
         case (r_state)
            S_WAIT_VS: w_state_next = S_WAIT_VS;
            S_WAIT_DE: if (de_in) w_state_next = S_ACTIVE;
            S_ACTIVE: begin
               if (w_de_fall) begin
                  w_state_next = S_HBLANK;
                  w_line_end   = 1'b1;
               end
            end
            S_HBLANK:  if (w_de_rise) w_state_next = S_ACTIVE;
            default:   w_state_next = S_WAIT_VS;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_WAIT_VS;
      else        r_state <= w_state_next;
   end

   // The pixel that moves WAIT_DE/HBLANK into ACTIVE is itself counted.
   assign w_count_pix = de_in & ~w_vs_rise & (r_state != S_WAIT_VS);
   assign w_pix_inc   = (r_pix_cnt == '1) ? r_pix_cnt : r_pix_cnt + 1'b1;
   assign w_line_inc  = (r_line_cnt == '1) ? r_line_cnt : r_line_cnt + 1'b1;
   assign w_commit    = w_vs_rise & (r_line_cnt != '0);

   assign w_timing_err_next = w_drop_line |
                              (w_line_end & (r_line_cnt != '0) & (r_pix_cnt != r_ref_w));
   assign w_res_change_next = w_commit & r_res_valid &
                              ((r_ref_w != r_frame_width) | (r_line_cnt != r_frame_height));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync_q      <= 1'b0;
         r_de_q         <= 1'b0;
         r_pix_cnt      <= '0;
         r_line_cnt     <= '0;
         r_ref_w        <= '0;
         r_frame_width  <= '0;
         r_frame_height <= '0;
         r_res_valid    <= 1'b0;
         r_res_change   <= 1'b0;
         r_timing_err   <= 1'b0;
         r_frame_cnt    <= '0;
         r_cfg_ready    <= 1'b1;
         r_pend_mode    <= 2'b00;
         r_mode_active  <= 2'b00;
         r_conv_en      <= 1'b0;
      end else begin
         r_vsync_q    <= vsync_in;
         r_de_q       <= de_in;
         r_timing_err <= w_timing_err_next;
         r_res_change <= w_res_change_next;
         r_conv_en    <= de_in & (r_mode_active == 2'b01);

         if (w_vs_rise) begin
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_frame_cnt <= r_frame_cnt + 1'b1;
            if (w_commit) begin
               r_frame_width  <= r_ref_w;
               r_frame_height <= r_line_cnt;
               r_res_valid    <= 1'b1;
            end
         end else if (w_line_end) begin
            r_line_cnt <= w_line_inc;
            if (r_line_cnt == '0) r_ref_w <= r_pix_cnt;
            r_pix_cnt  <= '0;
         end else if (w_count_pix) begin
            r_pix_cnt <= w_pix_inc;
         end

         // cfg_ready low means a request is pending. A request accepted on
         // the vsync edge itself waits for the following frame boundary.
         if (w_vs_rise && !r_cfg_ready)
            r_mode_active <= (r_pend_mode == 2'b11) ? 2'b00 : r_pend_mode;
         if (w_accept) begin
            r_pend_mode <= cfg_mode;
            r_cfg_ready <= 1'b0;
         end else if (w_vs_rise) begin
            r_cfg_ready <= 1'b1;
         end
      end
   end

   // Mux select delay line, oldest stage in the top two bits.
   generate
      if (CONV_LAT == 1) begin : g_lat1
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_mode_sr <= '0;
            else        r_mode_sr <= r_mode_active;
         end
      end else begin : g_latn
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_mode_sr <= '0;
            else        r_mode_sr <= {r_mode_sr[2*CONV_LAT-3:0], r_mode_active};
         end
      end
   endgenerate

`ifdef FRAME_CTRL_IRQ_EN
   logic r_irq;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      r_irq <= 1'b0;
      else if (w_res_change_next | w_timing_err_next)  r_irq <= 1'b1;
      else if (irq_clr)                                r_irq <= 1'b0;
   end
   assign irq = r_irq;
`endif

   assign cfg_ready    = r_cfg_ready;
   assign mode_active  = r_mode_active;
   assign conv_en      = r_conv_en;
   assign mode_sel_out = r_mode_sr[2*CONV_LAT-1 -: 2];
   assign frame_width  = r_frame_width;
   assign frame_height = r_frame_height;
   assign res_valid    = r_res_valid;
   assign res_change   = r_res_change;
   assign timing_err   = r_timing_err;
   assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_ycbcr_frame_ctrl.sv
// Testbench for ycbcr_frame_ctrl: directed frames followed by random frames,
// checked against a frame-level model of resolution, errors and mode.
module tb_ycbcr_frame_ctrl;

   localparam int CNT_W    = 12;
   localparam int CONV_LAT = 4;
   localparam int FCNT_W   = 16;

   logic              clk;
   logic              rst_n;
   logic              de_in;
   logic              hsync_in;
   logic              vsync_in;
   logic [1:0]        cfg_mode;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [1:0]        mode_active;
   logic              conv_en;
   logic [1:0]        mode_sel_out;
   logic [CNT_W-1:0]  frame_width;
   logic [CNT_W-1:0]  frame_height;
   logic              res_valid;
   logic              res_change;
   logic              timing_err;
   logic [FCNT_W-1:0] frame_cnt;

   ycbcr_frame_ctrl #(
      .CNT_W    (CNT_W),
      .CONV_LAT (CONV_LAT),
      .FCNT_W   (FCNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .de_in        (de_in),
      .hsync_in     (hsync_in),
      .vsync_in     (vsync_in),
      .cfg_mode     (cfg_mode),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .mode_active  (mode_active),
      .conv_en      (conv_en),
      .mode_sel_out (mode_sel_out),
      .frame_width  (frame_width),
      .frame_height (frame_height),
      .res_valid    (res_valid),
      .res_change   (res_change),
      .timing_err   (timing_err),
      .frame_cnt    (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // pulse counters sampled on the falling edge
   int cnt_terr = 0;
   int cnt_rchg = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (timing_err) cnt_terr <= cnt_terr + 1;
         if (res_change) cnt_rchg <= cnt_rchg + 1;
      end
   end

   // frame-level reference model
   int m_mode, m_pm, m_w, m_h, m_lines, m_refw, m_fcnt;
   int m_terr_total, m_rchg_total;
   bit m_pending, m_armed, m_rv;

   int f_len [8];
   int f_n;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_mode = 0; m_pm = 0; m_w = 0; m_h = 0; m_lines = 0; m_refw = 0; m_fcnt = 0;
      m_pending = 0; m_armed = 0; m_rv = 0;
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_width"},  frame_width, 0);
      check_val({tag, "_height"}, frame_height, 0);
      check_val({tag, "_rv"},     res_valid, 0);
      check_val({tag, "_rchg"},   res_change, 0);
      check_val({tag, "_terr"},   timing_err, 0);
      check_val({tag, "_conv"},   conv_en, 0);
      check_val({tag, "_msel"},   mode_sel_out, 0);
      check_val({tag, "_mode"},   mode_active, 0);
      check_val({tag, "_fcnt"},   frame_cnt, 0);
      check_val({tag, "_ready"},  cfg_ready, 1);
   endtask

   task automatic set_frame(input int n, input int w);
      f_n = n;
      for (int i = 0; i < 8; i++) f_len[i] = w;
   endtask

   // Drive the lines of one frame (no vsync). Optional request in the
   // hblank after line req_line; optional trailing line left open.
   task automatic run_frame(input bit trunc, input int req_line, input logic [1:0] req_mode);
      for (int i = 0; i < f_n; i++) begin
         de_in = 1'b1;
         for (int p = 0; p < f_len[i]; p++) begin
            tick();
            check_val("conv_en", conv_en, (m_mode == 1) ? 1 : 0);
         end
         de_in = 1'b0;
         tick();
         check_val("conv_en_off", conv_en, 0);
         if (i == req_line) begin
            cfg_valid = 1'b1;
            cfg_mode  = req_mode;
            tick();
            cfg_valid = 1'b0;
            if (!m_pending) begin
               m_pending = 1;
               m_pm      = req_mode;
            end
            check_val("cfg_ready_acc", cfg_ready, m_pending ? 0 : 1);
         end
         repeat (1 + $urandom_range(0, 2)) tick();
         check_val("cfg_ready_hold", cfg_ready, m_pending ? 0 : 1);
      end
      if (m_armed) begin
         m_lines = f_n;
         m_refw  = (f_n > 0) ? f_len[0] : 0;
         for (int i = 1; i < f_n; i++)
            if (f_len[i] != f_len[0]) m_terr_total++;
      end
      if (trunc) begin
         de_in = 1'b1;
         repeat (3) begin
            tick();
            check_val("conv_en_tr", conv_en, (m_mode == 1) ? 1 : 0);
         end
      end
   endtask

   // vsync rising edge plus the following vertical blank
   task automatic boundary(input bit trunc, input bit sim_req, input logic [1:0] sim_mode);
      int old_mode;
      bit exp_rchg, exp_terr, ready_before;
      old_mode = m_mode;
      exp_rchg = 0;
      exp_terr = m_armed && trunc;
      if (exp_terr) m_terr_total++;
      if (m_armed && m_lines > 0) begin
         if (m_rv && (m_refw != m_w || m_lines != m_h)) exp_rchg = 1;
         m_w = m_refw; m_h = m_lines; m_rv = 1;
      end
      if (exp_rchg) m_rchg_total++;
      m_fcnt++;
      ready_before = !m_pending;
      if (m_pending) begin
         m_mode    = (m_pm == 3) ? 0 : m_pm;
         m_pending = 0;
      end
      if (sim_req && ready_before) begin
         m_pending = 1;
         m_pm      = sim_mode;
      end
      m_armed = 1;
      m_lines = 0;

      vsync_in  = 1'b1;
      de_in     = trunc;
      cfg_valid = sim_req;
      cfg_mode  = sim_mode;
      tick();
      vsync_in  = 1'b0;
      de_in     = 1'b0;
      cfg_valid = 1'b0;
      check_val("res_change", res_change, exp_rchg);
      check_val("timing_err_vs", timing_err, exp_terr);
      check_val("frame_width", frame_width, m_w);
      check_val("frame_height", frame_height, m_h);
      check_val("res_valid", res_valid, m_rv);
      check_val("mode_active", mode_active, m_mode);
      check_val("cfg_ready_vs", cfg_ready, m_pending ? 0 : 1);
      check_val("frame_cnt", frame_cnt, m_fcnt);
      check_val("conv_en_vs", conv_en, (trunc && old_mode == 1) ? 1 : 0);
      $display("frame %0d: width=%0d height=%0d res_valid=%0d mode=%0d", m_fcnt, frame_width, frame_height, res_valid, mode_active);
      for (int k = 1; k <= CONV_LAT; k++) begin
         tick();
         if (k == 1) begin
            check_val("terr_cnt", cnt_terr, m_terr_total);
            check_val("rchg_cnt", cnt_rchg, m_rchg_total);
         end
         if (k == CONV_LAT - 1) check_val("mode_sel_old", mode_sel_out, old_mode);
         if (k == CONV_LAT)     check_val("mode_sel_new", mode_sel_out, m_mode);
      end
      repeat (2) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, w;
      bit tr, sr;
      model_reset();
      m_terr_total = 0;
      m_rchg_total = 0;
      rst_n = 1'b0; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      cfg_mode = 2'b00; cfg_valid = 1'b0;

      // activity while held in reset
      for (int i = 0; i < 6; i++) begin
         de_in = i[0];
         vsync_in = (i == 3);
         tick();
      end
      de_in = 1'b0; vsync_in = 1'b0;
      check_reset_state("rst");
      rst_n = 1'b1;
      tick();

      // de pulses before the first vsync are ignored
      set_frame(2, 5);
      run_frame(0, -1, 2'b00);
      check_val("fcnt_prevs", frame_cnt, 0);
      check_val("terr_prevs", cnt_terr, m_terr_total);
      check_val("rv_prevs", res_valid, 0);
      boundary(0, 0, 2'b00);

      // 6x4 frames, then 8x4
      set_frame(4, 6); run_frame(0, -1, 2'b00); boundary(0, 0, 2'b00);
      set_frame(4, 6); run_frame(0, -1, 2'b00); boundary(0, 0, 2'b00);
      set_frame(4, 8); run_frame(0, -1, 2'b00); boundary(0, 0, 2'b00);

      // short third line
      set_frame(4, 6); f_len[2] = 5; run_frame(0, -1, 2'b00); boundary(0, 0, 2'b00);

      // mode request mid-frame
      set_frame(3, 6); run_frame(0, 1, 2'b01); boundary(0, 0, 2'b00);

      // request coincident with vsync rise
      set_frame(3, 6); run_frame(0, -1, 2'b00); boundary(0, 1, 2'b10);
      set_frame(3, 6); run_frame(0, -1, 2'b00); boundary(0, 0, 2'b00);

      // line truncated by vsync
      set_frame(2, 6); run_frame(1, -1, 2'b00); boundary(1, 0, 2'b00);
      set_frame(2, 6); run_frame(0, 0, 2'b11);  boundary(0, 0, 2'b00);
      set_frame(2, 6); run_frame(0, 0, 2'b01);  boundary(0, 0, 2'b00);

      // random frames
      for (int f = 0; f < 30; f++) begin
         n = $urandom_range(0, 5);
         w = $urandom_range(1, 12);
         set_frame(n, w);
         for (int i = 0; i < n; i++)
            if ($urandom_range(0, 4) == 0) f_len[i] = $urandom_range(1, 12);
         tr = ($urandom_range(0, 7) == 0);
         sr = ($urandom_range(0, 5) == 0);
         run_frame(tr, $urandom_range(0, 7), 2'($urandom_range(0, 3)));
         boundary(tr, sr, 2'($urandom_range(0, 3)));
      end

      // reset in the middle of a line
      de_in = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0;
      #2;
      check_reset_state("mid_rst");
      de_in = 1'b0;
      model_reset();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // partial frame after reset is not measured
      set_frame(2, 7); run_frame(0, -1, 2'b00); boundary(0, 0, 2'b00);
      check_val("rv_after_rst", res_valid, 0);
      set_frame(3, 9); run_frame(0, -1, 2'b00); boundary(0, 0, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ycbcr_frame_ctrl.md
Name: ycbcr_frame_ctrl

Overview:
Frame-level controller in front of the rgb2ycbcr converter and its bypass mux. It tracks de_in/hsync_in/vsync_in and measures active width and height. It accepts mode-change requests through a valid/ready handshake and applies each change only on a frame boundary (vsync rising edge). It drives the converter enable and a mux select delayed to match the converter latency, so output frames are never mixed-mode.

Parameters:
CNT_W, 12, width of pixel/line counters and measured resolution
CONV_LAT, 4, converter pipeline latency in clk cycles (>=1); delay applied to mode_sel_out
FCNT_W, 16, width of frame counter

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, asynchronous, active-low
de_in  in  1  data enable, active-high
hsync_in  in  1  horizontal sync, active-high
vsync_in  in  1  vertical sync, active-high
cfg_mode  in  2  requested mode: 00 bypass, 01 convert, 10 blank, 11 reserved (treated as 00)
cfg_valid  in  1  mode request valid
cfg_ready  out  1  controller can accept a request
mode_active  out  2  mode in force for the current frame
conv_en  out  1  converter enable
mode_sel_out  out  2  mode_active delayed CONV_LAT cycles, for the output mux
frame_width  out  CNT_W  active pixels per line, last completed frame
frame_height  out  CNT_W  active lines, last completed frame
res_valid  out  1  frame_width/height hold a measured value
res_change  out  1  1-cycle pulse: committed resolution differs from previous
timing_err  out  1  1-cycle pulse: line length differs from first line of frame
frame_cnt  out  FCNT_W  frames started since reset, wraps

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, cfg_ready=1, mode_active=00, FSM=WAIT_VS, counters and delay line cleared.
- vs_rise = vsync_in & ~vsync_q, where vsync_q is the registered vsync_in. de_fall and de_rise are formed the same way from a registered de_in.
- FSM:
  - WAIT_VS: ignore de_in until vs_rise, then go to WAIT_DE.
  - WAIT_DE: on de_in=1, go to ACTIVE.
  - ACTIVE: de_in=1 increments pix_cnt. On de_fall, go to HBLANK and end the line.
  - HBLANK: de_rise goes to ACTIVE.
  - vs_rise in any state other than WAIT_VS goes to WAIT_DE and runs the frame-boundary actions.
- Line end:
  - line_cnt++.
  - If this is the first line of the frame, ref_w = pix_cnt.
  - Otherwise, if pix_cnt != ref_w, pulse timing_err.
  - pix_cnt clears.
  - pix_cnt and line_cnt saturate at all-ones.
- Frame-boundary actions (on vs_rise):
  - frame_cnt++ (wraps).
  - If line_cnt>0: commit frame_width=ref_w and frame_height=line_cnt, set res_valid=1. Pulse res_change if res_valid was already 1 and the values differ.
  - If line_cnt=0, the measurement is unchanged.
  - line_cnt clears.
  - A pending request is applied to mode_active. Reserved value 11 maps to 00.
- A vs_rise during ACTIVE (line not terminated) still runs the frame-boundary actions. The partial line is dropped and timing_err pulses.
- Handshake:
  - A request is accepted when cfg_valid & cfg_ready; cfg_ready drops the next cycle and the value is stored as pending.
  - The pending value is applied at the next vs_rise, and cfg_ready returns to 1 the cycle after that.
  - An accept in the same cycle as a vs_rise is not applied until the following vs_rise.
- conv_en = de_in & (mode_active==01), registered: 1-cycle latency from de_in.
- mode_sel_out is a CONV_LAT-stage shift register of mode_active.
- Reset mid-frame returns to WAIT_VS. The first partial frame after reset is never measured.

Optional Feature:
FRAME_CTRL_IRQ_EN. When defined, adds two ports:
- irq (out, 1): level output, set by res_change or timing_err, cleared by irq_clr.
- irq_clr (in, 1): a set event in the same cycle as irq_clr wins.
When not defined, these ports do not exist and there is no extra logic.

Test Plan:
- Reset values: hold rst_n=0 mid-stream -> all outputs 0, cfg_ready=1, mode_active=00; de pulses before the first vsync are ignored, frame_cnt=0.
- Resolution: frames of 4 lines x 6 pixels, 2-cycle hblank -> after the 2nd vs_rise frame_width=6, frame_height=4, res_valid=1, res_change=0; change to 8x4 -> res_change pulses once at the next vs_rise.
- Line mismatch: line 3 of the frame is 5 pixels while the others are 6 -> a single timing_err pulse at the de_fall of line 3.
- Mode change: request cfg_mode=01 mid-frame -> cfg_ready=0 until the next vs_rise; mode_active=01 the cycle after vs_rise; mode_sel_out follows CONV_LAT=4 cycles later; conv_en tracks de_in with 1-cycle delay.
- Simultaneous: cfg_valid=1, cfg_mode=10 in the same cycle as vs_rise -> mode unchanged for that frame, becomes 10 at the next vs_rise.
- Truncated line: vsync rises while de=1 -> timing_err pulse, FSM in WAIT_DE, line not counted.
